bit_word_collector: RTL
=======================

Name: bit_word_collector

Overview:
- Downstream consumer of the single-bit registered/muxed stream produced by the sequential select stage.
- Gathers WIDTH consecutive accepted bits into a parallel word and presents it on a valid/ready output port.
- Double-buffered: a shift register fills while the previous word waits in the output register, so back-to-back words flow with no bubble.
- Feeds the word-wide datapath that follows.

Parameters:
- WIDTH, 8, bits per output word; legal range 2..64.
- LSB_FIRST, 1, 1: first accepted bit lands in out_data[0]; 0: first accepted bit lands in out_data[WIDTH-1].
- CNT_W, derived as ceil(log2(WIDTH+1)), width of bit_count; not overridable.

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is presented this cycle.
- in_ready  output  1  collector can accept in_bit this cycle.
- out_data  output  WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer takes out_data this cycle.
- bit_count  output  CNT_W  bits currently held in the shift register (0..WIDTH-1).

Behaviour:
- Reset and handshake rules:
  - Reset asserts asynchronously and deasserts synchronously into CLK.
  - While ASYNCRESETN=0: shift register=0, bit_count=0, out_data=0, out_valid=0.
  - in_ready is combinational: in_ready = (bit_count != WIDTH-1) | !out_valid | out_ready.
  - Accept: in_valid & in_ready at a rising edge. Drain: out_valid & out_ready at a rising edge.
- Bit placement:
  - LSB_FIRST=1: accepted bit k of a word (k=0..WIDTH-1) goes to position k.
  - LSB_FIRST=0: it goes to position WIDTH-1-k.
- Accept with bit_count < WIDTH-1:
  - Bit is written into the shift register.
  - bit_count increments by 1.
- Accept with bit_count = WIDTH-1 (word completion):
  - Full word, including this bit, is loaded into out_data at the same edge.
  - out_valid=1 from the next cycle, so latency is 1 cycle from the last-bit accept.
  - bit_count returns to 0 and the shift register clears to 0.
- Drain with no simultaneous completion:
  - out_valid falls.
  - out_data keeps its last value.
- Simultaneous drain and completion on the same edge:
  - out_data takes the new word and out_valid stays 1. No bubble, no loss.
- Stall: bit_count = WIDTH-1, out_valid=1, out_ready=0.
  - in_ready=0.
  - Shift register and bit_count hold.
  - in_bit is ignored even if in_valid=1.
- Stability: while out_valid=1 and out_ready=0, out_data is held stable.
- Idle input: in_valid=0 leaves the shift register and bit_count unchanged; partial words wait indefinitely.
- out_ready while out_valid=0 has no effect.
- in_bit is don't-care when in_valid=0.
- Reset mid-word or mid-hold: the partial word and the held word are both discarded; no output is produced for them.
- No combinational path from in_valid/in_bit to any output. in_ready depends combinationally on out_ready only.

Optional Feature:
- Macro: BIT_WORD_COLLECTOR_PARITY_EN.
- When defined:
  - Extra output port out_parity (1 bit) carries the even-parity bit (XOR reduction) of out_data.
  - It is registered together with out_data and follows the same hold/reset rules; reset value is 0.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset: hold ASYNCRESETN=0 with in_valid=1, out_ready=1 for 3 cycles -> out_valid=0, out_data=0, bit_count=0, no word emitted. Release reset -> in_ready=1.
2. WIDTH=8, LSB_FIRST=1, out_ready=1: accept bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th accept, out_data=8'h4D, out_valid=1 for exactly one cycle; bit_count sequence 1..7 then 0. With PARITY_EN, out_parity=0.
3. Same sequence with LSB_FIRST=0 -> out_data=8'hB2.
4. Backpressure: out_ready=0, stream 16 bits (words 8'hFF, then 8'h01 LSB-first) -> first word held at 8'hFF. After 7 more accepts, in_ready=0 and bit_count stays 7 while in_valid=1. Raise out_ready for one cycle -> 8th bit of the second word accepted that edge, out_data=8'h01, out_valid stays 1.
5. Gapped input: in_valid toggles 1/0 each cycle over a word -> out_data identical to the gap-free case. bit_count holds on idle cycles.
6. Reset mid-word: assert ASYNCRESETN=0 asynchronously (between edges) after 5 accepted bits -> bit_count=0 immediately. Next 8 accepts produce a clean word with no leftover bits.

Source files
------------

// File: rtl/bit_word_collector_if.sv
// Serial-in / word-out handshake bundle for bit_word_collector.
// master: the environment (bit source and word consumer).
// slave:  the collector itself.
// Optional out_parity member exists only when BIT_WORD_COLLECTOR_PARITY_EN is defined.
interface bit_word_collector_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_count;
`ifdef BIT_WORD_COLLECTOR_PARITY_EN
    logic             out_parity;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_data, out_valid, bit_count, out_parity
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_data, out_valid, bit_count, out_parity
    );
`else
    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_data, out_valid, bit_count
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_data, out_valid, bit_count
    );
`endif
endinterface

// File: rtl/bit_word_collector.sv
// bit_word_collector: gathers WIDTH accepted serial bits into a word and
// presents it on a valid/ready port. A shift register fills while the
// previous word waits in the output register, so words flow back-to-back.
// Optional feature macro: BIT_WORD_COLLECTOR_PARITY_EN adds out_parity,
// the XOR reduction of out_data, registered alongside it.
module bit_word_collector #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    bit_word_collector_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic             last_bit;
    logic             accept;
    logic             drain;
    logic             complete;
    logic [CNT_W-1:0] bit_pos;
    logic [WIDTH-1:0] word_next;

    // Handshake qualifiers; in_ready only stalls when a full word would
    // have nowhere to go, and it sees out_ready so a drain frees the slot.
    always_comb begin
        last_bit     = (bit_cnt == LAST_CNT);
        bus.in_ready = !last_bit || !valid_q || bus.out_ready;
        accept       = bus.in_valid && bus.in_ready;
        drain        = valid_q && bus.out_ready;
        complete     = accept && last_bit;
    end

    // Position of the incoming bit and the shift register with it merged in.
    always_comb begin
        bit_pos   = LSB_FIRST ? bit_cnt : (LAST_CNT - bit_cnt);
        word_next = shift_reg;
        for (int i = 0; i < WIDTH; i++) begin
            if (CNT_W'(i) == bit_pos) begin
                word_next[i] = bus.in_bit;
            end
        end
    end

    // Fill side: collect bits, clear once a completed word moves out.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (complete) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= word_next;
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    // Output side: load on completion (even while draining), otherwise
    // drop valid on drain and keep the data as it was.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (complete) begin
            data_q  <= word_next;
            valid_q <= 1'b1;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

`ifdef BIT_WORD_COLLECTOR_PARITY_EN
    logic parity_q;

    // Parity travels with the word it describes.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            parity_q <= 1'b0;
        end else if (complete) begin
            parity_q <= ^word_next;
        end
    end

    // Parity output drive.
    always_comb begin
        bus.out_parity = parity_q;
    end
`endif

    // Registered outputs.
    always_comb begin
        bus.out_data  = data_q;
        bus.out_valid = valid_q;
        bus.bit_count = bit_cnt;
    end
endmodule
